// File: rtl/button_press_counter.sv
// Two debounced push-buttons step a wrapping up/down count for the LED bank.
// Each accepted press produces exactly one registered pulse; releases never pulse.

module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      CHECK_HIGH  = 2'd1,
      STABLE_HIGH = 2'd2,
      CHECK_LOW   = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic            stable;
   logic            stable_next;
   logic            stable_prev;
   logic            s1;
   logic            s;

   // Synchroniser, debounce state and edge-detect registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1          <= 1'b0;
         s           <= 1'b0;
         state       <= STABLE_LOW;
         count       <= '0;
         stable      <= 1'b0;
         stable_prev <= 1'b0;
         pulse       <= 1'b0;
      end else begin
         s1          <= raw;
         s           <= s1;
         state       <= state_next;
         count       <= count_next;
         stable      <= stable_next;
         stable_prev <= stable;
         pulse       <= stable & ~stable_prev;
      end
   end

   // Any bounce back to the old level restarts the whole window.
   always_comb begin
      state_next  = state;
      count_next  = count;
      stable_next = stable;
      case (state)
         STABLE_LOW: begin
            if (s) begin
               state_next = CHECK_HIGH;
               count_next = CW'(1);
            end else begin
               count_next = '0;
            end
         end
         CHECK_HIGH: begin
            if (!s) begin
               state_next = STABLE_LOW;
               count_next = '0;
            end else if (count == LAST) begin
               state_next  = STABLE_HIGH;
               count_next  = '0;
               stable_next = 1'b1;
            end else begin
               count_next = count + CW'(1);
            end
         end
         STABLE_HIGH: begin
            if (!s) begin
               state_next = CHECK_LOW;
               count_next = CW'(1);
            end else begin
               count_next = '0;
            end
         end
         CHECK_LOW: begin
            if (s) begin
               state_next = STABLE_HIGH;
               count_next = '0;
            end else if (count == LAST) begin
               state_next  = STABLE_LOW;
               count_next  = '0;
               stable_next = 1'b0;
            end else begin
               count_next = count + CW'(1);
            end
         end
         default: begin
            state_next  = STABLE_LOW;
            count_next  = '0;
            stable_next = 1'b0;
         end
      endcase
   end

endmodule

module button_press_counter #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             button_up,
   input  logic             button_down,
   output logic [WIDTH-1:0] counter,
   output logic             press_up,
   output logic             press_down
);

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk   (clk),
      .reset (reset),
      .raw   (button_up),
      .pulse (press_up)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk   (clk),
      .reset (reset),
      .raw   (button_down),
      .pulse (press_down)
   );

   // Wrapping count; simultaneous presses cancel.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
      end else begin
         case ({press_up, press_down})
            2'b10:   counter <= counter + WIDTH'(1);
            2'b01:   counter <= counter - WIDTH'(1);
            default: counter <= counter;
         endcase
      end
   end

endmodule

// File: tb/tb_button_press_counter.sv
// Directed bench for button_press_counter with DEBOUNCE_CYCLES = 4.
`timescale 1ns/1ps

module tb_button_press_counter;

   logic       clk;
   logic       reset;
   logic       button_up;
   logic       button_down;
   logic [3:0] counter;
   logic       press_up;
   logic       press_down;

   int errors;
   int checks;
   int up_pulses;
   int down_pulses;

   button_press_counter #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .button_up   (button_up),
      .button_down (button_down),
      .counter     (counter),
      .press_up    (press_up),
      .press_down  (press_down)
   );

   initial clk = 1'b0;
   always #2.5 clk = ~clk;

   always @(negedge clk) begin
      if (press_up)   up_pulses   = up_pulses + 1;
      if (press_down) down_pulses = down_pulses + 1;
   end

   task automatic check_value(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (observed !== expected) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic up, input logic down, input int high, input int low);
      button_up   = up;
      button_down = down;
      repeat (high) tick();
      button_up   = 1'b0;
      button_down = 1'b0;
      repeat (low) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   int start_up;
   int start_down;
   logic [3:0] expect_count;

   initial begin
      errors      = 0;
      checks      = 0;
      up_pulses   = 0;
      down_pulses = 0;
      reset       = 1'b1;
      button_up   = 1'b0;
      button_down = 1'b0;
      tick();

      // Reset held with buttons toggling.
      for (int i = 0; i < 20; i++) begin
         button_up   = i[0];
         button_down = ~i[0];
         tick();
         check_value("reset_hold", {counter, press_up, press_down}, 32'd0);
      end
      reset       = 1'b0;
      button_up   = 1'b0;
      button_down = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         check_value("idle_after_reset", {counter, press_up, press_down}, 32'd0);
      end

      // Clean press: pulse after 7 ticks (E0+6), counter after 8 (E0+7).
      start_up   = up_pulses;
      button_up  = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 6 || i == 7 || i == 8) begin
            check_value("clean_pulse", 32'(press_up), (i == 7) ? 32'd1 : 32'd0);
            check_value("clean_count", 32'(counter), (i >= 8) ? 32'd1 : 32'd0);
         end
      end
      button_up = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_value("release_no_pulse", 32'(press_up), 32'd0);
      end
      check_value("clean_pulse_total", 32'(up_pulses - start_up), 32'd1);
      check_value("clean_count_final", 32'(counter), 32'd1);

      // Bounce pattern alone: rejected.
      start_up = up_pulses;
      press(1'b1, 1'b0, 2, 0);
      press(1'b0, 1'b0, 1, 0);
      press(1'b1, 1'b0, 3, 0);
      press(1'b0, 1'b0, 16, 0);
      check_value("bounce_no_pulse", 32'(up_pulses - start_up), 32'd0);
      check_value("bounce_count", 32'(counter), 32'd1);

      // Bounce pattern followed by a solid hold: one pulse.
      start_up = up_pulses;
      press(1'b1, 1'b0, 2, 0);
      press(1'b0, 1'b0, 1, 0);
      press(1'b1, 1'b0, 3, 0);
      press(1'b0, 1'b0, 1, 0);
      press(1'b1, 1'b0, 10, 16);
      check_value("bounce_then_hold_pulse", 32'(up_pulses - start_up), 32'd1);
      check_value("bounce_then_hold_count", 32'(counter), 32'd2);

      // Wrap-around both directions.
      do_reset();
      check_value("wrap_start", 32'(counter), 32'd0);
      press(1'b0, 1'b1, 12, 12);
      check_value("wrap_down", 32'(counter), 32'hF);
      expect_count = 4'hF;
      for (int i = 0; i < 17; i++) begin
         press(1'b1, 1'b0, 12, 12);
         expect_count = expect_count + 4'd1;
         check_value("wrap_up_step", 32'(counter), 32'(expect_count));
      end
      check_value("wrap_up_final", 32'(counter), 32'h0);

      // Simultaneous press at count 5.
      do_reset();
      for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 12, 12);
      check_value("simul_setup", 32'(counter), 32'd5);
      start_up    = up_pulses;
      start_down  = down_pulses;
      button_up   = 1'b1;
      button_down = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 7) begin
            check_value("simul_up_pulse", 32'(press_up), 32'd1);
            check_value("simul_down_pulse", 32'(press_down), 32'd1);
         end
      end
      button_up   = 1'b0;
      button_down = 1'b0;
      repeat (16) tick();
      check_value("simul_up_total", 32'(up_pulses - start_up), 32'd1);
      check_value("simul_down_total", 32'(down_pulses - start_down), 32'd1);
      check_value("simul_count", 32'(counter), 32'd5);

      // Reset in the cycle press_up is high: no increment.
      do_reset();
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 12, 12);
      check_value("midreset_setup", 32'(counter), 32'd3);
      button_up = 1'b1;
      repeat (7) tick();
      check_value("midreset_pulse_seen", 32'(press_up), 32'd1);
      reset = 1'b1;
      tick();
      check_value("midreset_count", 32'(counter), 32'd0);
      check_value("midreset_pulse_cleared", 32'(press_up), 32'd0);

      // Button held across reset release counts once.
      tick();
      start_up = up_pulses;
      reset    = 1'b0;
      repeat (20) tick();
      button_up = 1'b0;
      repeat (16) tick();
      check_value("held_reset_pulses", 32'(up_pulses - start_up), 32'd1);
      check_value("held_reset_count", 32'(counter), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
